// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcodes and default geometry for the SPI-attached RAM.
package spi_ram_pkg;
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } opcode_t;
  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_SIZE_DEF = 8;
endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: byte storage with one write port and one registered read port, no reset.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH_DEF,
  parameter int AW = ADDR_SIZE_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/spi_ram.sv
// spi_ram: command decoder for an SPI slave front end; SPI_RAM_ERR_EN adds the sticky cmd_err output.
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
`ifdef SPI_RAM_ERR_EN
  ,
  output logic       cmd_err
`endif
);
  logic                 prev_rx, accept, dout_clr;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic [7:0]           rdata;
  opcode_t              op;
  assign op     = opcode_t'(din[9:8]);
  assign accept = rx_valid & ~prev_rx & ~rst;
  // the read register has no reset, so dout is forced to zero until the first read after reset
  assign dout   = dout_clr ? '0 : rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_rx  <= 1'b0;
      tx_valid <= 1'b0;
      dout_clr <= 1'b1;
      wr_addr  <= '0;
      rd_addr  <= '0;
    end else begin
      prev_rx <= rx_valid;
      if (accept) begin
        tx_valid <= op == CMD_RD_DATA;
        if (op == CMD_RD_DATA) dout_clr <= 1'b0;
        if (op == CMD_WR_ADDR) wr_addr <= din[ADDR_SIZE-1:0];
        if (op == CMD_WR_DATA) wr_addr <= wr_addr + 1'b1;
        if (op == CMD_RD_ADDR) rd_addr <= din[ADDR_SIZE-1:0];
      end
    end
  end
`ifdef SPI_RAM_ERR_EN
  logic rd_armed, wa_set;
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_err  <= 1'b0;
      rd_armed <= 1'b0;
      wa_set   <= 1'b0;
    end else if (accept) begin
      cmd_err  <= cmd_err | (op == CMD_RD_DATA && !rd_armed) | (op == CMD_WR_DATA && !wa_set);
      rd_armed <= op == CMD_RD_ADDR ? 1'b1 : op == CMD_RD_DATA ? 1'b0 : rd_armed;
      wa_set   <= wa_set | (op == CMD_WR_ADDR);
    end
  end
`endif
  spi_ram_mem #(.DEPTH(MEM_DEPTH), .AW(ADDR_SIZE)) u_mem (
    .clk  (clk),
    .we   (accept && op == CMD_WR_DATA),
    .waddr(wr_addr),
    .wdata(din[7:0]),
    .re   (accept && op == CMD_RD_DATA),
    .raddr(rd_addr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: randomized and directed checks of spi_ram against a command-level memory model.
module tb_spi_ram;
  logic       clk = 0, rst = 0, rx_valid = 0;
  logic [9:0] din = '0;
  logic [7:0] dout;
  logic       tx_valid;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] mm [256];
  int         wa, ra;
  logic [7:0] exp_dout;
  logic       exp_tx, exp_err, armed, waset;
`ifdef SPI_RAM_ERR_EN
  logic cmd_err;
  spi_ram dut (.clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(dout), .tx_valid(tx_valid), .cmd_err(cmd_err));
`else
  spi_ram dut (.clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(dout), .tx_valid(tx_valid));
`endif
  always #5 clk = ~clk;

  task automatic model_reset();
    wa = 0; ra = 0; exp_dout = 8'h00; exp_tx = 0; exp_err = 0; armed = 0; waset = 0;
  endtask

  task automatic model_apply(input logic [9:0] c);
    int op = int'(c[9:8]);
    if ((op == 3 && !armed) || (op == 1 && !waset)) exp_err = 1;
    if (op == 0) begin wa = int'(c[7:0]); waset = 1; end
    if (op == 1) begin mm[wa] = c[7:0]; wa = (wa + 1) % 256; end
    if (op == 2) begin ra = int'(c[7:0]); armed = 1; end
    if (op == 3) begin exp_dout = mm[ra]; armed = 0; end
    exp_tx = (op == 3);
  endtask

  task automatic send(input logic [9:0] c, input int hold);
    @(negedge clk);
    din = c; rx_valid = 1;
    repeat (hold) @(negedge clk);
    rx_valid = 0;
    model_apply(c);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx: got %b want 0", tx_valid); end
`ifdef SPI_RAM_ERR_EN
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", cmd_err); end
`endif
  endtask

  task automatic fill_memory();
    send(10'h000, 1);
    for (int i = 0; i < 256; i++) send({2'b01, 8'($urandom)}, 1);
    n_cmp++; if (wa !== 0) begin n_bad++; $display("FAIL fill_wrap: model wa %0d want 0", wa); end
  endtask

  task automatic test_write_read();
    send(10'h012, 1); send(10'h1A5, 1); send(10'h1B6, 1);
    send(10'h212, 1); send(10'h300, 1);
    n_cmp++; if (dout !== 8'hA5 || tx_valid !== 1'b1) begin n_bad++; $display("FAIL rd_12: got %h/%b want a5/1", dout, tx_valid); end
    repeat (4) @(negedge clk);
    n_cmp++; if (dout !== 8'hA5 || tx_valid !== 1'b1) begin n_bad++; $display("FAIL rd_12_hold: got %h/%b want a5/1", dout, tx_valid); end
    send(10'h213, 1);
    n_cmp++; if (tx_valid !== 1'b0 || dout !== 8'hA5) begin n_bad++; $display("FAIL tx_drop: got %h/%b want a5/0", dout, tx_valid); end
    send(10'h300, 1);
    n_cmp++; if (dout !== 8'hB6 || tx_valid !== 1'b1) begin n_bad++; $display("FAIL rd_13: got %h/%b want b6/1", dout, tx_valid); end
  endtask

  task automatic test_back_to_back();
    send(10'h212, 1); send(10'h300, 1); send(10'h300, 1);
    n_cmp++; if (dout !== 8'hA5 || tx_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_rd: got %h/%b want a5/1", dout, tx_valid); end
    send(10'h013, 1); send(10'h213, 1); send(10'h300, 1);
    send(10'h1EE, 1);
    n_cmp++; if (dout !== 8'hB6 || tx_valid !== 1'b0) begin n_bad++; $display("FAIL wr_rd_addr: got %h/%b want b6/0", dout, tx_valid); end
    send(10'h300, 1);
    n_cmp++; if (dout !== 8'hEE || tx_valid !== 1'b1) begin n_bad++; $display("FAIL rd_after_wr: got %h/%b want ee/1", dout, tx_valid); end
  endtask

  task automatic test_wrap();
    send(10'h0FF, 1); send(10'h111, 1); send(10'h122, 1);
    send(10'h2FF, 1); send(10'h300, 1);
    n_cmp++; if (dout !== 8'h11) begin n_bad++; $display("FAIL wrap_ff: got %h want 11", dout); end
    send(10'h200, 1); send(10'h300, 1);
    n_cmp++; if (dout !== 8'h22) begin n_bad++; $display("FAIL wrap_00: got %h want 22", dout); end
  endtask

  task automatic test_level_hold();
    send(10'h040, 1); send(10'h1C3, 5); send(10'h1D4, 1);
    send(10'h240, 1); send(10'h300, 1);
    n_cmp++; if (dout !== 8'hC3) begin n_bad++; $display("FAIL level_40: got %h want c3", dout); end
    send(10'h241, 1); send(10'h300, 1);
    n_cmp++; if (dout !== 8'hD4) begin n_bad++; $display("FAIL level_41: got %h want d4", dout); end
  endtask

  task automatic test_reset_mid_read();
    send(10'h212, 1); send(10'h300, 1);
    @(negedge clk); rst = 1; din = 10'h300; rx_valid = 1;
    @(negedge clk); rst = 0;
    model_reset();
    n_cmp++; if (dout !== 8'h00 || tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid: got %h/%b want 00/0", dout, tx_valid); end
    @(negedge clk); rx_valid = 0;
    model_apply(10'h300);
    n_cmp++; if (dout !== mm[0] || tx_valid !== 1'b1) begin n_bad++; $display("FAIL rst_held_rx: got %h/%b want %h/1", dout, tx_valid, mm[0]); end
    send(10'h212, 1); send(10'h300, 1);
    n_cmp++; if (dout !== 8'hA5) begin n_bad++; $display("FAIL rst_retain: got %h want a5", dout); end
  endtask

  task automatic test_err_path();
    do_reset();
    send(10'h300, 1);
    n_cmp++; if (dout !== mm[0] || tx_valid !== 1'b1) begin n_bad++; $display("FAIL unarmed_rd: got %h/%b want %h/1", dout, tx_valid, mm[0]); end
`ifdef SPI_RAM_ERR_EN
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", cmd_err); end
    send(10'h000, 1); send(10'h200, 1); send(10'h300, 1);
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", cmd_err); end
    do_reset();
    send(10'h155, 1);
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL err_wr_first: got %b want 1", cmd_err); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [1:0] op = 2'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send({op, 8'($urandom)}, $urandom_range(1, 3));
      n_cmp++; if (tx_valid !== exp_tx) begin n_bad++; $display("FAIL rnd_tx[%0d]: got %b want %b", i, tx_valid, exp_tx); end
      n_cmp++; if (dout !== exp_dout) begin n_bad++; $display("FAIL rnd_dout[%0d]: got %h want %h", i, dout, exp_dout); end
`ifdef SPI_RAM_ERR_EN
      n_cmp++; if (cmd_err !== exp_err) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want %b", i, cmd_err, exp_err); end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    fill_memory();
    test_write_read();
    test_back_to_back();
    test_wrap();
    test_level_hold();
    test_reset_mid_read();
    test_err_path();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256: number of 8-bit words.
REQ-002 SHALL have parameter ADDR_SIZE, default 8: address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge; the block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port din, input, 10: word from the SPI slave; [9:8] opcode, [7:0] payload.
REQ-006 SHALL have port rx_valid, input, 1: din valid; level, may stay high for several cycles.
REQ-007 SHALL have port dout, output, 8: read data to the SPI slave (its tx_data).
REQ-008 SHALL have port tx_valid, output, 1: dout valid (the slave's tx_valid).
REQ-009 SHALL have port cmd_err, output, 1: sticky protocol error; present only with SPI_RAM_ERR_EN.

Function
REQ-010 SHALL accept a command only on a rising edge of rx_valid (rx_valid=1, previous-cycle rx_valid=0); rx_valid high in the first cycle after reset counts as a rising edge.
REQ-011 SHALL ignore din in every cycle without an accepted command.
REQ-012 Opcode 00 (write address) SHALL load wr_addr <= din[ADDR_SIZE-1:0].
REQ-013 Opcode 01 (write data) SHALL write din[7:0] to mem[wr_addr] and then increment wr_addr.
REQ-014 wr_addr increment SHALL wrap from MEM_DEPTH-1 to 0.
REQ-015 Opcode 10 (read address) SHALL load rd_addr <= din[ADDR_SIZE-1:0] and set rd_armed.
REQ-016 Opcode 11 (read data) SHALL register mem[rd_addr] into dout one cycle after acceptance, assert tx_valid in that same cycle, and clear rd_armed.
REQ-017 rd_addr SHALL NOT auto-increment.
REQ-018 Opcode 11 with rd_armed=0 SHALL still read mem[rd_addr].
REQ-019 tx_valid SHALL stay high, and dout SHALL stay stable, until the next accepted command of any opcode; tx_valid SHALL then drop in the following cycle.
REQ-020 A read-data command accepted while tx_valid is high SHALL keep tx_valid high and update dout one cycle later.
REQ-021 A write to mem[rd_addr] while tx_valid is high SHALL NOT change dout.
REQ-022 Reads SHALL return memory contents after all writes accepted in earlier cycles; a read and write cannot coincide, since only one command is accepted per cycle.
REQ-023 Address bits din[7:ADDR_SIZE] SHALL be ignored when ADDR_SIZE < 8.

Reset
REQ-024 In a cycle with rst=1, the block SHALL set dout=0, tx_valid=0, cmd_err=0, wr_addr=0, rd_addr=0, rd_armed=0 and previous rx_valid=0.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 Reset SHALL override any command accepted in the same cycle.
REQ-027 A command pending at reset SHALL be dropped, and a level rx_valid held through reset SHALL be re-accepted per REQ-010.

Configuration
REQ-028 With SPI_RAM_ERR_EN defined, cmd_err SHALL set one cycle after an accepted opcode 11 with rd_armed=0, or an accepted opcode 01 before any opcode 00 since reset.
REQ-029 cmd_err SHALL stay set until reset.
REQ-030 With SPI_RAM_ERR_EN undefined, the cmd_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package spi_ram_pkg SHALL hold the opcode constants (CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11) and the default depth and width constants.
REQ-032 Storage SHALL be in sub-module spi_ram_mem: one write port, one synchronous read port, no reset.
REQ-033 Command decode, address registers, edge detect and tx_valid control SHALL stay in spi_ram.

Verification
REQ-034 Write sequence: 0x012, 0x1A5, 0x1B6 -> mem[0x12]=A5, mem[0x13]=B6.
REQ-035 Read-back: 0x212 then 0x300 -> dout=A5 and tx_valid=1 one cycle after acceptance; both held until the next rx_valid edge.
REQ-036 Wrap: 0x0FF, 0x111, 0x122 -> mem[0xFF]=11, mem[0x00]=22.
REQ-037 Level hold: rx_valid held high 5 cycles with din=0x1C3 -> exactly one write, wr_addr advances by 1.
REQ-038 Reset mid-read: rst pulsed while tx_valid=1 -> tx_valid=0 and dout=0 next cycle; memory retained (read of 0x12 returns A5).
REQ-039 ERR_EN: 0x300 after reset -> cmd_err=1 and sticky; without the macro, the same stimulus yields dout=mem[0].
